systolic_tile_engine: RTL and testbench

Parametrised successor to the fixed four-MAC top-level control: a self-sequencing MAC tile with N_MACS lanes, programmable reduction depth, and two dataflow modes. Mode 0 is systolic-skewed; mode 1 is broadcast. It accepts a stream of (activation, weight-vector) beats over a valid/ready handshake and accumulates K products per lane. It then presents all lane sums as one output beat with backpressure. It sits between the input/weight memory interfaces and the downstream result writer.

---
 rtl/systolic_tile_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_systolic_tile_engine.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_engine.sv
`timescale 1ns/1ps
// systolic_tile_engine: N_MACS-lane MAC tile, K beats per tile, skewed (mode 0) or broadcast (mode 1) dataflow.
// Latency: result valid S+2 cycles after last input accept (S = N_MACS-1 skewed, 0 broadcast); cfg_k==0 -> 1 cycle after start.
// Backpressure: in_ready high only in RUN; out_valid/out_acc hold until out_ready. Define TILE_SAT_EN for saturating lanes.
module systolic_tile_engine #(
    parameter int W      = 8,
    parameter int ACC_W  = 24,
    parameter int N_MACS = 4,
    parameter int K_MAX  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
    input  logic                         cfg_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_a,
    input  logic [N_MACS*W-1:0]          in_w,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_MACS*ACC_W-1:0]      out_acc,
    output logic [N_MACS-1:0]            sat_flag,
    output logic                         busy,
    output logic                         done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int FW = $clog2(N_MACS + 1);
    localparam logic [FW-1:0] S_SKEW = FW'(N_MACS - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

    state_t        state;
    logic [KW-1:0] cnt;
    logic [KW-1:0] k_q;
    logic          mode_q;
    logic [FW-1:0] fcnt;

    logic          fire;
    logic          start_acc;
    logic [KW-1:0] cnt_nxt;

    assign fire      = in_valid & in_ready;
    assign start_acc = start & (state == IDLE);
    assign cnt_nxt   = cnt + KW'(1);
    assign busy      = (state != IDLE);
    // done marks the handshake cycle itself, so the next start lands one cycle later
    assign done      = out_valid & out_ready;

    // Tile sequencing: beat counting, flush drain timing, result presentation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
            k_q       <= '0;
            mode_q    <= 1'b0;
            fcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_q    <= cfg_k;
                        mode_q <= cfg_mode;
                        cnt    <= '0;
                        if (cfg_k == '0) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt == k_q) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                            fcnt     <= mode_q ? '0 : S_SKEW;
                        end
                    end
                end
                FLUSH: begin
                    // wait until the deepest lane has folded its last product in
                    if (fcnt == '0) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        fcnt <= fcnt - FW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_MACS; i++) begin : g_lane
        logic signed [W-1:0]       tap_a;
        logic signed [W-1:0]       tap_w;
        logic                      tap_v;
        logic signed [W-1:0]       lane_w;
        logic signed [2*W-1:0]     ax;
        logic signed [2*W-1:0]     wx;
        logic signed [2*W-1:0]     prod;
        logic                      prod_v;
        logic signed [ACC_W-1:0]   prod_ext;
        logic signed [ACC_W-1:0]   acc;

        assign lane_w = in_w[i*W +: W];

        if (i == 0) begin : g_nodly
            assign tap_v = fire;
            assign tap_a = in_a;
            assign tap_w = lane_w;
        end else begin : g_dly
            logic signed [W-1:0] da [0:i-1];
            logic signed [W-1:0] dw [0:i-1];
            logic [i-1:0]        dv;

            // Skew line: lane i sees each beat i cycles late; bubbles travel as dv=0
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dv <= '0;
                    for (int j = 0; j < i; j++) begin
                        da[j] <= '0;
                        dw[j] <= '0;
                    end
                end else if (start_acc) begin
                    dv <= '0;
                end else begin
                    dv[0] <= fire;
                    da[0] <= in_a;
                    dw[0] <= lane_w;
                    for (int j = 1; j < i; j++) begin
                        dv[j] <= dv[j-1];
                        da[j] <= da[j-1];
                        dw[j] <= dw[j-1];
                    end
                end
            end

            assign tap_v = mode_q ? fire   : dv[i-1];
            assign tap_a = mode_q ? in_a   : da[i-1];
            assign tap_w = mode_q ? lane_w : dw[i-1];
        end

        assign ax       = {{W{tap_a[W-1]}}, tap_a};
        assign wx       = {{W{tap_w[W-1]}}, tap_w};
        assign prod_ext = ACC_W'(prod);

        // Registered multiply stage
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                prod   <= '0;
                prod_v <= 1'b0;
            end else if (start_acc) begin
                prod_v <= 1'b0;
            end else begin
                prod   <= ax * wx;
                prod_v <= tap_v;
            end
        end

`ifdef TILE_SAT_EN
        localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
        localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
        logic signed [ACC_W:0] sum;
        logic                  sat;

        assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);

        // Saturating accumulate; the top two sum bits disagree exactly on overflow
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc <= '0;
                sat <= 1'b0;
            end else if (start_acc) begin
                acc <= '0;
                sat <= 1'b0;
            end else if (prod_v) begin
                if (sum[ACC_W] != sum[ACC_W-1]) begin
                    acc <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    sat <= 1'b1;
                end else begin
                    acc <= sum[ACC_W-1:0];
                end
            end
        end

        assign sat_flag[i] = sat;
`else
        // Wrapping accumulate
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc <= '0;
            end else if (start_acc) begin
                acc <= '0;
            end else if (prod_v) begin
                acc <= acc + prod_ext;
            end
        end
`endif

        assign out_acc[i*ACC_W +: ACC_W] = acc;
    end

`ifndef TILE_SAT_EN
    assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_systolic_tile_engine.sv
`timescale 1ns/1ps
// Directed bench for systolic_tile_engine: two instances (ACC_W=24 and ACC_W=16) share all stimulus.
// Expected sums, latencies and flag values are hand-computed constants.
module tb_systolic_tile_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  cfg_k;
    logic        cfg_mode;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [31:0] in_w;
    logic        out_ready;

    logic        ir24, ov24, busy24, done24;
    logic [95:0] acc24;
    logic [3:0]  sat24;
    logic        ir16, ov16, busy16, done16;
    logic [63:0] acc16;
    logic [3:0]  sat16;

    int checks = 0;
    int errors = 0;
    int n;

    localparam logic [31:0] W_MIX = {8'sd0, 8'sd3, -8'sd2, 8'sd1};
    localparam logic [31:0] W_MAX = {4{8'sd127}};

    systolic_tile_engine #(.W(8), .ACC_W(24), .N_MACS(4), .K_MAX(64)) dut24 (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(ir24), .in_a(in_a), .in_w(in_w),
        .out_valid(ov24), .out_ready(out_ready), .out_acc(acc24),
        .sat_flag(sat24), .busy(busy24), .done(done24)
    );

    systolic_tile_engine #(.W(8), .ACC_W(16), .N_MACS(4), .K_MAX(64)) dut16 (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_mode(cfg_mode),
        .in_valid(in_valid), .in_ready(ir16), .in_a(in_a), .in_w(in_w),
        .out_valid(ov16), .out_ready(out_ready), .out_acc(acc16),
        .sat_flag(sat16), .busy(busy16), .done(done16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [31:0] lane24(input int i);
        logic signed [23:0] t;
        t = acc24[i*24 +: 24];
        return t;
    endfunction

    function automatic logic signed [31:0] lane16(input int i);
        logic signed [15:0] t;
        t = acc16[i*16 +: 16];
        return t;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input logic [6:0] k, input logic mode);
        start    = 1'b1;
        cfg_k    = k;
        cfg_mode = mode;
        step();
        start    = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [31:0] w);
        in_valid = 1'b1;
        in_a     = a;
        in_w     = w;
        step();
        in_valid = 1'b0;
    endtask

    // Called in the cycle after the last accept edge; n = cycles from that edge to out_valid
    task automatic wait_out(output int cyc);
        cyc = 1;
        while (!ov24 && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic check_mix(input string tag);
        check({tag, "_l0"}, lane24(0), 4);
        check({tag, "_l1"}, lane24(1), -8);
        check({tag, "_l2"}, lane24(2), 12);
        check({tag, "_l3"}, lane24(3), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; start = 1'b0; cfg_k = '0; cfg_mode = 1'b0;
        in_valid = 1'b0; in_a = '0; in_w = '0; out_ready = 1'b1;
        #12;
        // reset state
        check("rst_in_ready", ir24, 0);
        check("rst_out_valid", ov24, 0);
        check("rst_busy", busy24, 0);
        check("rst_done", done24, 0);
        check("rst_sat", sat24, 0);
        for (int i = 0; i < 4; i++) check("rst_acc", lane24(i), 0);
        rst = 1'b1;
        step();

        // skewed K=3
        start_tile(7'd3, 1'b0);
        check("skew_in_ready_up", ir24, 1);
        check("skew_busy", busy24, 1);
        send(8'sd2, W_MIX);
        send(8'sd3, W_MIX);
        send(-8'sd1, W_MIX);
        check("skew_in_ready_down", ir24, 0);
        wait_out(n);
        check("skew_latency", n, 5);
        check_mix("skew");
        check("skew_done", done24, 1);
        step();
        check("skew_out_valid_low", ov24, 0);
        check("skew_idle", busy24, 0);
        check("skew_done_low", done24, 0);

        // broadcast K=3, started right after the previous done
        start_tile(7'd3, 1'b1);
        check("bc_busy", busy24, 1);
        send(8'sd2, W_MIX);
        send(8'sd3, W_MIX);
        send(-8'sd1, W_MIX);
        wait_out(n);
        check("bc_latency", n, 2);
        check_mix("bc");
        check("bc_done", done24, 1);
        step();
        check("bc_idle", busy24, 0);

        // skewed with input gaps and output backpressure
        out_ready = 1'b0;
        start_tile(7'd3, 1'b0);
        send(8'sd2, W_MIX);
        step(); step();
        send(8'sd3, W_MIX);
        check("gap_in_ready", ir24, 1);
        step(); step();
        check("gap_in_ready2", ir24, 1);
        send(-8'sd1, W_MIX);
        wait_out(n);
        check("gap_latency", n, 5);
        check_mix("gap");
        for (int c = 0; c < 4; c++) begin
            step();
            check("stall_out_valid", ov24, 1);
            check("stall_done", done24, 0);
            check("stall_l1", lane24(1), -8);
            check("stall_l2", lane24(2), 12);
        end
        out_ready = 1'b1;
        #1;
        check("stall_done_pulse", done24, 1);
        step();
        check("stall_done_after", done24, 0);
        check("stall_out_valid_after", ov24, 0);

        // overflow: 3 x (127*127) = 48387
        start_tile(7'd3, 1'b0);
        send(8'sd127, W_MAX);
        send(8'sd127, W_MAX);
        send(8'sd127, W_MAX);
        wait_out(n);
        check("sat_latency", n, 5);
        check("sat_acc24_l0", lane24(0), 48387);
        check("sat_acc24_flag", sat24, 0);
`ifdef TILE_SAT_EN
        for (int i = 0; i < 4; i++) check("sat_acc16", lane16(i), 32767);
        check("sat_flag16", sat16, 15);
`else
        for (int i = 0; i < 4; i++) check("wrap_acc16", lane16(i), -17149);
        check("wrap_flag16", sat16, 0);
`endif
        step();
        check("sat_idle", busy24, 0);

        // cfg_k=0, start during OUT is ignored
        out_ready = 1'b0;
        start_tile(7'd0, 1'b0);
        check("k0_out_valid", ov24, 1);
        for (int i = 0; i < 4; i++) check("k0_acc", lane24(i), 0);
        start = 1'b1; cfg_k = 7'd3;
        step();
        start = 1'b0;
        check("k0_ignore_ov", ov24, 1);
        check("k0_ignore_ir", ir24, 0);
        out_ready = 1'b1;
        step();
        check("k0_ov_low", ov24, 0);
        check("k0_idle", busy24, 0);

        // reset mid-RUN after two beats
        start_tile(7'd3, 1'b0);
        send(8'sd2, W_MIX);
        send(8'sd3, W_MIX);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy24, 0);
        check("mid_rst_in_ready", ir24, 0);
        check("mid_rst_out_valid", ov24, 0);
        check("mid_rst_done", done24, 0);
        for (int i = 0; i < 4; i++) check("mid_rst_acc", lane24(i), 0);
        #1;
        rst = 1'b1;
        step();
        start_tile(7'd3, 1'b0);
        send(8'sd2, W_MIX);
        send(8'sd3, W_MIX);
        send(-8'sd1, W_MIX);
        wait_out(n);
        check("post_rst_latency", n, 5);
        check_mix("post_rst");
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
